// File: rtl/max_wr_scoreboard_pkg.sv
// rtl/max_wr_scoreboard_pkg.sv - shared constants and queue entry type for the MAX write scoreboard
package max_sb_pkg;
  localparam int SLOT_W = 4;
  localparam int SLOTS  = 16;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [DATA_W-1:0] oprndA;
    logic [DATA_W-1:0] oprndB;
  } max_sb_entry_t;
endpackage

// File: rtl/max_wr_scoreboard_if.sv
// rtl/max_wr_scoreboard_if.sv - execute-side write request, result-buffer write and read-observe signals
interface max_wr_scoreboard_if;
  import max_sb_pkg::*;

  logic              wr_req;
  logic [SLOT_W-1:0] wr_slot;
  logic [DATA_W-1:0] wr_oprndA;
  logic [DATA_W-1:0] wr_oprndB;
  logic              wr_rdy;
  logic              rdenA;
  logic              rdenB;
  logic [SLOT_W-1:0] rdaddrsA;
  logic [SLOT_W-1:0] rdaddrsB;
  logic              consume;
  logic [SLOT_W-1:0] consume_slot;
  logic              wren;
  logic [SLOT_W-1:0] wraddrs;
  logic [DATA_W-1:0] oprndA;
  logic [DATA_W-1:0] oprndB;
  logic [SLOTS-1:0]  slot_valid;
  logic              hazA;
  logic              hazB;
  logic              ovr_err;
  logic [1:0]        pend_cnt;

  modport slave (
    input  wr_req, wr_slot, wr_oprndA, wr_oprndB, rdenA, rdenB, rdaddrsA, rdaddrsB,
           consume, consume_slot,
    output wr_rdy, wren, wraddrs, oprndA, oprndB, slot_valid, hazA, hazB, ovr_err, pend_cnt
  );

  modport master (
    output wr_req, wr_slot, wr_oprndA, wr_oprndB, rdenA, rdenB, rdaddrsA, rdaddrsB,
           consume, consume_slot,
    input  wr_rdy, wren, wraddrs, oprndA, oprndB, slot_valid, hazA, hazB, ovr_err, pend_cnt
  );
endinterface

// File: rtl/max_wr_scoreboard_fifo.sv
// rtl/max_wr_scoreboard_fifo.sv - 2-entry FIFO of pending result-buffer writes (module max_sb_fifo)
module max_sb_fifo
  import max_sb_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic          pop,
  input  max_sb_entry_t pushData,
  output max_sb_entry_t headData,
  output logic [1:0]    count
);
  max_sb_entry_t mem [2];
  logic          wrPtr;
  logic          rdPtr;
  logic          doPush;
  logic          doPop;

  assign doPush   = push && (count != 2'd2);
  assign doPop    = pop && (count != 2'd0);
  assign headData = mem[rdPtr];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (doPush) wrPtr <= ~wrPtr;
      if (doPop)  rdPtr <= ~rdPtr;
      case ({doPush, doPop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by count in the parent.
  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/max_wr_scoreboard.sv
// rtl/max_wr_scoreboard.sv - write issue gating and per-slot valid scoreboard for the MAX result buffer
// Read-collision deferral is built only when MAX_SB_RD_DEFER_EN is defined.
module max_wr_scoreboard
  import max_sb_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  max_wr_scoreboard_if.slave  bus
);
  max_sb_entry_t     pushData;
  max_sb_entry_t     headData;
  logic [1:0]        pendCnt;
  logic              wrRdy;
  logic              wrenC;
  logic              notEmpty;
  logic [SLOTS-1:0]  slotValid;
  logic [SLOTS-1:0]  setMask;
  logic [SLOTS-1:0]  clrMask;
  logic              ovrErr;

  assign pushData = '{slot: bus.wr_slot, oprndA: bus.wr_oprndA, oprndB: bus.wr_oprndB};
  assign notEmpty = (pendCnt != 2'd0);
  assign wrRdy    = (pendCnt < 2'(DEPTH));

`ifdef MAX_SB_RD_DEFER_EN
  assign wrenC = notEmpty && !(bus.rdenA || bus.rdenB);
`else
  assign wrenC = notEmpty;
`endif

  max_sb_fifo uFifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (bus.wr_req && wrRdy),
    .pop      (wrenC),
    .pushData (pushData),
    .headData (headData),
    .count    (pendCnt)
  );

  assign setMask = wrenC ? (SLOTS'(1) << headData.slot) : '0;
  assign clrMask = bus.consume ? (SLOTS'(1) << bus.consume_slot) : '0;

  // Set is applied after clear so a same-slot set/clear leaves the slot valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      slotValid <= '0;
      ovrErr    <= 1'b0;
    end else begin
      slotValid <= (slotValid & ~clrMask) | setMask;
      if (wrenC && slotValid[headData.slot] && !clrMask[headData.slot]) ovrErr <= 1'b1;
    end
  end

  assign bus.wr_rdy     = wrRdy;
  assign bus.wren       = wrenC;
  assign bus.wraddrs    = notEmpty ? headData.slot   : '0;
  assign bus.oprndA     = notEmpty ? headData.oprndA : '0;
  assign bus.oprndB     = notEmpty ? headData.oprndB : '0;
  assign bus.slot_valid = slotValid;
  assign bus.hazA       = bus.rdenA && !slotValid[bus.rdaddrsA];
  assign bus.hazB       = bus.rdenB && !slotValid[bus.rdaddrsB];
  assign bus.ovr_err    = ovrErr;
  assign bus.pend_cnt   = pendCnt;
endmodule

// File: tb/tb_max_wr_scoreboard.sv
// tb/tb_max_wr_scoreboard.sv - scoreboard-based directed bench for max_wr_scoreboard
module tb_max_wr_scoreboard;
  import max_sb_pkg::*;

`ifdef MAX_SB_RD_DEFER_EN
  localparam bit DEFER = 1'b1;
`else
  localparam bit DEFER = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  max_wr_scoreboard_if bus ();
  max_wr_scoreboard dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int compared = 0;
  int mismatched = 0;
  max_sb_entry_t    exp_q[$];
  logic [SLOTS-1:0] svM = '0;
  logic             ovrM = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [SLOT_W-1:0] slot,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic rA, input logic [SLOT_W-1:0] aA,
                       input logic rB, input logic [SLOT_W-1:0] aB,
                       input logic cons, input logic [SLOT_W-1:0] cslot);
    bus.wr_req = req; bus.wr_slot = slot; bus.wr_oprndA = a; bus.wr_oprndB = b;
    bus.rdenA = rA; bus.rdaddrsA = aA; bus.rdenB = rB; bus.rdaddrsB = aB;
    bus.consume = cons; bus.consume_slot = cslot;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [SLOT_W-1:0] slot, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    drive(1'b1, slot, a, b, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Compare every output against the model mid-cycle, then advance the model across the edge.
  task automatic tick();
    logic expWren, expRdy, accept, clrHit;
    max_sb_entry_t head, pushed;
    @(negedge CLK);
    expWren = (exp_q.size() != 0) && (!DEFER || !(bus.rdenA || bus.rdenB));
    expRdy  = (exp_q.size() < 2);
    head    = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("wren", 64'(bus.wren), 64'(expWren));
    chk("wr_rdy", 64'(bus.wr_rdy), 64'(expRdy));
    chk("pend_cnt", 64'(bus.pend_cnt), 64'(exp_q.size()));
    chk("slot_valid", 64'(bus.slot_valid), 64'(svM));
    chk("ovr_err", 64'(bus.ovr_err), 64'(ovrM));
    chk("hazA", 64'(bus.hazA), 64'(bus.rdenA && !svM[bus.rdaddrsA]));
    chk("hazB", 64'(bus.hazB), 64'(bus.rdenB && !svM[bus.rdaddrsB]));
    chk("wraddrs", 64'(bus.wraddrs), 64'(head.slot));
    chk("oprndA", bus.oprndA, head.oprndA);
    chk("oprndB", bus.oprndB, head.oprndB);
    if (!RESET) begin
      exp_q.delete(); svM = '0; ovrM = 1'b0;
    end else begin
      accept = bus.wr_req && expRdy;
      pushed = '{slot: bus.wr_slot, oprndA: bus.wr_oprndA, oprndB: bus.wr_oprndB};
      clrHit = bus.consume && (bus.consume_slot == head.slot);
      if (expWren && svM[head.slot] && !clrHit) ovrM = 1'b1;
      if (bus.consume) svM[bus.consume_slot] = 1'b0;
      if (expWren) begin
        svM[head.slot] = 1'b1;
        void'(exp_q.pop_front());
      end
      if (accept) exp_q.push_back(pushed);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    tick();
    tick();
    RESET = 1'b1;
    tick();

    // Single write with reads idle
    wr(4'd3, 64'd5, 64'd9);
    tick();
    idle();
    tick();
    tick();
    chk("slot3_map", 64'(bus.slot_valid), 64'h0008);

    // Writes under an active read
    drive(1'b1, 4'd1, 64'h11, 64'h21, 1'b1, 4'd3, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b1, 4'd2, 64'h12, 64'h22, 1'b1, 4'd3, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b1, 4'd4, 64'h14, 64'h24, 1'b1, 4'd3, 1'b0, '0, 1'b0, '0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();

    // Read hazard on an unwritten slot, cleared by a write
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 4'd7, 1'b0, '0);
    tick();
    wr(4'd7, 64'h77, 64'h78);
    tick();
    idle();
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 4'd7, 1'b0, '0);
    tick();
    chk("hazB_after_write", 64'(bus.hazB), 64'd0);

    // Same-edge consume and rewrite of slot 5: no overwrite error, slot stays valid
    wr(4'd5, 64'h50, 64'h51);
    tick();
    idle();
    tick();
    wr(4'd5, 64'h52, 64'h53);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 4'd5);
    tick();
    idle();
    tick();
    chk("consume_set_wins", 64'(bus.slot_valid[5]), 64'd1);
    chk("no_ovr_on_consume", 64'(bus.ovr_err), 64'd0);

    // Overwrite without consume sets the sticky error
    wr(4'd5, 64'h54, 64'h55);
    tick();
    idle();
    tick();
    tick();
    chk("ovr_sticky", 64'(bus.ovr_err), 64'd1);

    // Fill every slot back to back
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 64'(i * 3 + 1), 64'(i * 7 + 2));
      tick();
    end
    idle();
    tick();
    tick();
    chk("full_map", 64'(bus.slot_valid), 64'hFFFF);

    // Asynchronous reset with writes pending
    drive(1'b1, 4'd9, 64'h99, 64'h9A, 1'b1, 4'd0, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b1, 4'd10, 64'hA0, 64'hA1, 1'b1, 4'd0, 1'b0, '0, 1'b0, '0);
    tick();
    #2 RESET = 1'b0;
    #1;
    chk("rst_pend_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("rst_slot_valid", 64'(bus.slot_valid), 64'd0);
    chk("rst_ovr_err", 64'(bus.ovr_err), 64'd0);
    chk("rst_wren", 64'(bus.wren), 64'd0);
    exp_q.delete(); svM = '0; ovrM = 1'b0;
    tick();
    RESET = 1'b1;
    idle();
    tick();

    // Back-to-back writes with a constant read
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(8 + i), 64'(100 + i), 64'(200 + i), 1'b1, 4'd0, 1'b0, '0, 1'b0, '0);
      tick();
`ifndef MAX_SB_RD_DEFER_EN
      chk("pend_le1", 64'(bus.pend_cnt <= 2'd1), 64'd1);
`endif
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
